// File: rtl/user_module_bcd_countdown.sv
// Two-digit BCD preset countdown timer for an 8-in/8-out tile: digit-serial preset
// entry, sticky done at 00, and a multiplexed bit-reversed digit bus.
module user_module_bcd_countdown (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic       w_clk;
  logic       w_rst;
  logic       w_load;
  logic       w_en;
  logic [3:0] w_data;
  logic [3:0] w_data_clamped;
  logic       w_nonzero;
  logic       w_count;
  logic       w_last_step;
  logic       w_running;
  logic [3:0] w_digit;

  logic [3:0] r_units;
  logic [3:0] r_tens;
  logic       r_done;
  logic       r_borrow;
  logic       r_sel;

  assign w_clk  = io_in[7];
  assign w_rst  = io_in[6];
  assign w_load = io_in[0];
  assign w_en   = io_in[1];
  assign w_data = io_in[5:2];

  // Non-BCD codes (A-F) are treated as the largest legal digit.
  assign w_data_clamped = (w_data > 4'd9) ? 4'd9 : w_data;

  assign w_nonzero   = (r_tens != 4'd0) || (r_units != 4'd0);
  assign w_count     = w_en && w_nonzero;
  assign w_last_step = (r_tens == 4'd0) && (r_units == 4'd1);
  assign w_running   = w_en && w_nonzero;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_units  <= 4'd0;
      r_tens   <= 4'd0;
      r_done   <= 1'b0;
      r_borrow <= 1'b0;
      r_sel    <= 1'b0;
    end else begin
      r_sel <= ~r_sel;
      if (w_load) begin
        // Shift-in entry: the previously entered digit becomes the tens digit.
        r_tens   <= r_units;
        r_units  <= w_data_clamped;
        r_done   <= 1'b0;
        r_borrow <= 1'b0;
      end else if (w_count) begin
        if (r_units != 4'd0) begin
          r_units  <= r_units - 4'd1;
          r_borrow <= 1'b0;
        end else begin
          r_units  <= 4'd9;
          r_tens   <= r_tens - 4'd1;
          r_borrow <= 1'b1;
        end
        if (w_last_step) begin
          r_done <= 1'b1;
        end
      end else begin
        r_borrow <= 1'b0;
      end
    end
  end

  assign w_digit = r_sel ? r_tens : r_units;

  // Digit bus is wired MSB-first onto io_out[0].
  assign io_out = {r_done, r_sel, w_running, r_borrow,
                   w_digit[0], w_digit[1], w_digit[2], w_digit[3]};

endmodule

// File: tb/tb_user_module_bcd_countdown.sv
// Directed bench for the BCD countdown timer: hand-computed expected io_out values
// for reset, digit entry, countdown, clamping, load priority and async reset.
module tb_user_module_bcd_countdown;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       load = 1'b0;
  logic       en   = 1'b0;
  logic [3:0] data = 4'd0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  int   n_cmp   = 0;
  int   n_bad   = 0;
  logic exp_sel = 1'b0;

  assign io_in = {clk, rst, data, en, load};

  user_module_bcd_countdown dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Expected io_out for a given two-digit value and flags, at the bench's tracked sel.
  function automatic logic [7:0] pack(input int value, input logic b, input logic d);
    logic [3:0] t;
    logic [3:0] u;
    logic [3:0] g;
    t = 4'(value / 10);
    u = 4'(value % 10);
    g = exp_sel ? t : u;
    return {d, exp_sel, en && (value != 0), b, g[0], g[1], g[2], g[3]};
  endfunction

  task automatic expect_state(input string tag, input int value, input logic b, input logic d);
    check_eq(tag, io_out, pack(value, b, d));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) exp_sel = ~exp_sel;
  endtask

  task automatic load_digit(input logic [3:0] v);
    load = 1'b1;
    data = v;
    step();
    load = 1'b0;
    data = 4'd0;
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  initial begin
    #200000;
    n_cmp++;
    n_bad++;
    $display("FAIL timeout: simulation did not complete");
    finish_run();
  end

  initial begin
    logic [3:0] sel_pat;
    int         v;

    // Reset held, enable high: everything reads zero.
    en = 1'b1;
    #2;
    check_eq("reset_async", io_out, 8'h00);
    step();
    check_eq("reset_held_edge1", io_out, 8'h00);
    step();
    check_eq("reset_held_edge2", io_out, 8'h00);
    rst = 1'b0;
    exp_sel = 1'b0;

    // sel alternates 1,0,1,0; digits 0, done 0, running 0 despite enable.
    sel_pat = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("post_reset_sel", {7'd0, io_out[6]}, {7'd0, sel_pat[3 - i]});
      check_eq("post_reset_out", io_out, {1'b0, sel_pat[3 - i], 6'd0});
    end

    // Digit entry 4 then 2 with enable low.
    en = 1'b0;
    load_digit(4'd4);
    expect_state("load4", 4, 1'b0, 1'b0);
    load_digit(4'd2);
    expect_state("load42", 42, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check_eq("digit_bus_42", {4'd0, io_out[3:0]}, exp_sel ? 8'h02 : 8'h04);
      step();
    end

    // Preset 12 and count down 12 edges; borrow after edge 3 only.
    load_digit(4'd1);
    expect_state("load_21", 21, 1'b0, 1'b0);
    load_digit(4'd2);
    expect_state("load_12", 12, 1'b0, 1'b0);
    en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      expect_state($sformatf("cnt12_e%0d", i), 12 - i, (i == 3), (i == 12));
    end
    check_eq("cnt12_running_low", {7'd0, io_out[5]}, 8'h00);
    step();
    expect_state("cnt12_e13_hold", 0, 1'b0, 1'b1);

    // Clamp C,F to 99 and count 99 edges; borrow whenever units wraps to 9.
    en = 1'b0;
    load_digit(4'hC);
    expect_state("clamp_C", 9, 1'b0, 1'b0);
    load_digit(4'hF);
    expect_state("clamp_F", 99, 1'b0, 1'b0);
    en = 1'b1;
    for (int i = 1; i <= 99; i++) begin
      step();
      v = 99 - i;
      expect_state($sformatf("cnt99_e%0d", i), v, ((v % 10) == 9), (i == 99));
    end

    // Load 3,5 (clears done), then load 7 with enable high: 57, not 56.
    en = 1'b0;
    load_digit(4'd3);
    expect_state("load3_clears_done", 3, 1'b0, 1'b0);
    load_digit(4'd5);
    expect_state("load35", 35, 1'b0, 1'b0);
    en = 1'b1;
    load_digit(4'd7);
    expect_state("load_over_en_57", 57, 1'b0, 1'b0);

    // Freeze and resume.
    step();
    expect_state("run_56", 56, 1'b0, 1'b0);
    en = 1'b0;
    step();
    expect_state("freeze_a", 56, 1'b0, 1'b0);
    step();
    expect_state("freeze_b", 56, 1'b0, 1'b0);
    en = 1'b1;
    step();
    expect_state("resume_55", 55, 1'b0, 1'b0);

    // Async reset mid-count at 23, between edges.
    en = 1'b0;
    load_digit(4'd2);
    load_digit(4'd3);
    expect_state("load23", 23, 1'b0, 1'b0);
    en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_eq("midcount_reset_async", io_out, 8'h00);
    step();
    check_eq("midcount_reset_held", io_out, 8'h00);
    rst = 1'b0;
    exp_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_state("after_reset_stays_00", 0, 1'b0, 1'b0);
    end

    finish_run();
  end

endmodule

// File: doc/user_module_bcd_countdown.md
# user_module_bcd_countdown

Two-digit BCD down-counter: the counting-down counterpart of the team's single-digit decade up-counter, for use as a preset countdown timer on a TinyTapeout tile. The operator enters a preset one digit at a time over a 4-bit BCD bus. The block then decrements once per enabled clock and stops at 00, raising a sticky done flag. Both digits share one 4-bit output bus through a select line that toggles every clock, for multiplexed display.

## Interface
Parameters: none. All widths are fixed by the tile's 8-in/8-out pin budget.
- io_in[7]  input  1  clock; rising-edge
- io_in[6]  input  1  reset; asynchronous, active-high
- io_in[0]  input  1  load; digit-serial preset entry strobe
- io_in[1]  input  1  enable; count-down enable
- io_in[5:2]  input  4  load data, BCD; io_in[5] is MSB
- io_out[3:0]  output  4  displayed BCD digit, bit-reversed bus order: io_out[0]=bit3, io_out[1]=bit2, io_out[2]=bit1, io_out[3]=bit0
- io_out[4]  output  1  borrow; 1-cycle pulse, units wrapped 0→9
- io_out[5]  output  1  running; enable & (count != 00)
- io_out[6]  output  1  digit select; 0 = units shown, 1 = tens shown
- io_out[7]  output  1  done; sticky, set on reaching 00 by counting

## Operation
- State registers:
  - units[3:0], tens[3:0]: BCD, always 0–9
  - done
  - borrow
  - sel
- Reset (async, io_in[6]=1):
  - units=0, tens=0, done=0, borrow=0, sel=0
  - all io_out bits read 0 while reset is held
- Priority at each rising edge: load > count > hold.
- Load (io_in[0]=1):
  - tens <= units; units <= clamp(data), where data > 9 loads as 9
  - done <= 0; borrow <= 0
  - No decrement on that edge, even if enable=1.
  - Two loads enter a two-digit preset, tens digit first.
- Count (load=0, enable=1, count != 00):
  - units != 0: units <= units-1, tens unchanged, borrow <= 0
  - units == 0: units <= 9, tens <= tens-1, borrow <= 1
  - Next value is 00: done <= 1.
- Hold (enable=0, or count == 00):
  - digits unchanged, borrow <= 0, done holds
  - Enable at 00 never wraps to 99.
- Running: io_out[5] = enable & ((tens|units) != 0). Combinational from current registers and enable pin.
- Select:
  - sel toggles on every clock edge, unconditionally (load and count do not affect it)
  - displayed digit = sel ? tens : units, driven combinationally from registers onto the bit-reversed bus
- Done:
  - stays 0 after reset, even though the count is 00
  - set only by a count edge that produces 00
  - cleared only by load or reset

## Timing
- All register updates occur on the rising edge of io_in[7]. Reset acts immediately, independent of the clock.
- Load latency: data present at edge k appears on the digit bus after edge k, when sel selects that digit.
- Count from preset N (00 < N ≤ 99):
  - exactly N enabled edges reach 00
  - done rises after edge N; running falls in the same cycle
- borrow is high for exactly the one cycle following the edge that decremented tens. A preset of X0 gives borrow after the 1st enabled edge.
- Dropping enable freezes the count. Re-asserting it resumes with no lost or extra step.
- Reset asserted mid-count clears everything asynchronously. The count restarts only after new loads.
- Load and enable in the same cycle: load takes effect and the count is unchanged by enable.
- Inputs are assumed synchronous to io_in[7]. No internal synchronizers.

## Test plan
- Reset, then 4 clocks:
  - io_out = 0x00 during reset
  - after reset, sel alternates 1,0,1,0
  - digits 0, done=0, running=0 with enable=1
- Load 4 then 2 (enable=0):
  - tens=4, units=2
  - io_out[3:0] reads 4'b0100 (bit-reversed 2) when sel=0, 4'b0010 (bit-reversed 4) when sel=1
- Load 1,2, then enable for 12 edges:
  - sequence 12,11,10,09,…,00
  - borrow high only after edge 3
  - done=1 and running=0 after edge 12
  - a 13th enabled edge keeps 00
- Load 0xC, then 0xF: clamps to 99. Enable 99 edges: done rises exactly at edge 99.
- Load asserted with enable=1 at count 35, data=7:
  - count becomes 57, not 56
  - done cleared
- Assert reset asynchronously mid-count at 23 (between edges): outputs zero immediately, and the count stays 00 after release.
